// File: rtl/ifetch_if.sv
// Fetch-stage bus: ROB redirect/training, JALR resolve, I-cache request/response
// and decoder hand-off. "master" is the fetch side, "slave" the environment.
interface ifetch_if #(
    parameter int BHT_BITS = 8
);
    logic                rdy_in;
    logic                rob_clear;
    logic [31:0]         new_pc;
    logic                is_b_res;
    logic [BHT_BITS-1:0] b_res_pc_part;
    logic                b_res_jmp;
    logic                jalr_resolved;
    logic [31:0]         jalr_target;
    logic                ic_req;
    logic [31:0]         ic_addr;
    logic                ic_ready;
    logic [31:0]         ic_ins;
    logic                dec_stall;
    logic                if_valid;
    logic [31:0]         if_ins;
    logic [31:0]         if_pc;
    logic                if_pred_jmp;

    modport master (
        input  rdy_in, rob_clear, new_pc, is_b_res, b_res_pc_part, b_res_jmp,
               jalr_resolved, jalr_target, ic_ready, ic_ins, dec_stall,
        output ic_req, ic_addr, if_valid, if_ins, if_pc, if_pred_jmp
    );

    modport slave (
        output rdy_in, rob_clear, new_pc, is_b_res, b_res_pc_part, b_res_jmp,
               jalr_resolved, jalr_target, ic_ready, ic_ins, dec_stall,
        input  ic_req, ic_addr, if_valid, if_ins, if_pc, if_pred_jmp
    );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch: one outstanding I-cache request, predecode with a 2-bit
// BHT for branches, JALR stall until resolve, and ROB flush redirect.
module ifetch #(
    parameter int BHT_BITS = 8
) (
    input  logic     clk_in,
    input  logic     rst_in,
    ifetch_if.master bus
);
    localparam int         BHT_N     = 1 << BHT_BITS;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {S_REQ, S_WAIT, S_ISSUE, S_STUCK, S_DROP} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pred_pc_q, pred_pc_d;
    logic        jalr_q, jalr_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_ins_q, if_ins_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        if_pred_q, if_pred_d;
    logic [1:0]  bht_q [BHT_N];

    logic [6:0]  opc;
    logic [31:0] j_imm, b_imm, pd_pc;
    logic        pd_jmp;
    logic [1:0]  bht_rd;

    // Predecode of the word arriving from the cache; pc_q is its address.
    always_comb begin
        opc    = bus.ic_ins[6:0];
        j_imm  = {{12{bus.ic_ins[31]}}, bus.ic_ins[19:12], bus.ic_ins[20],
                  bus.ic_ins[30:21], 1'b0};
        b_imm  = {{20{bus.ic_ins[31]}}, bus.ic_ins[7], bus.ic_ins[30:25],
                  bus.ic_ins[11:8], 1'b0};
        bht_rd = bht_q[pc_q[BHT_BITS:1]];
        pd_pc  = pc_q + 32'd4;
        pd_jmp = 1'b0;
        case (opc)
            OP_JAL: begin
                pd_pc  = pc_q + j_imm;
                pd_jmp = 1'b1;
            end
            OP_BRANCH: begin
                if (bht_rd[1]) begin
                    pd_pc  = pc_q + b_imm;
                    pd_jmp = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pred_pc_d  = pred_pc_q;
        jalr_d     = jalr_q;
        if_valid_d = if_valid_q;
        if_ins_d   = if_ins_q;
        if_pc_d    = if_pc_q;
        if_pred_d  = if_pred_q;
        if (bus.rob_clear) begin
            // A request issued but not yet answered must be swallowed in DROP.
            pc_d       = bus.new_pc;
            if_valid_d = 1'b0;
            case (state_q)
                S_REQ:          state_d = S_DROP;
                S_WAIT, S_DROP: state_d = bus.ic_ready ? S_REQ : S_DROP;
                default:        state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: state_d = S_WAIT;
                S_WAIT: begin
                    if (bus.ic_ready) begin
                        state_d    = S_ISSUE;
                        if_valid_d = 1'b1;
                        if_ins_d   = bus.ic_ins;
                        if_pc_d    = pc_q;
                        if_pred_d  = pd_jmp;
                        pred_pc_d  = pd_pc;
                        jalr_d     = (opc == OP_JALR);
                    end
                end
                S_ISSUE: begin
                    if (!bus.dec_stall) begin
                        if_valid_d = 1'b0;
                        if (jalr_q) begin
                            state_d = S_STUCK;
                        end else begin
                            pc_d    = pred_pc_q;
                            state_d = S_REQ;
                        end
                    end
                end
                S_STUCK: begin
                    if (bus.jalr_resolved) begin
                        pc_d    = bus.jalr_target;
                        state_d = S_REQ;
                    end
                end
                S_DROP:  if (bus.ic_ready) state_d = S_REQ;
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= S_REQ;
            pc_q       <= '0;
            pred_pc_q  <= '0;
            jalr_q     <= 1'b0;
            if_valid_q <= 1'b0;
            if_ins_q   <= '0;
            if_pc_q    <= '0;
            if_pred_q  <= 1'b0;
        end else if (bus.rdy_in) begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pred_pc_q  <= pred_pc_d;
            jalr_q     <= jalr_d;
            if_valid_q <= if_valid_d;
            if_ins_q   <= if_ins_d;
            if_pc_q    <= if_pc_d;
            if_pred_q  <= if_pred_d;
        end
    end

    // Training follows ROB commits only; fetch state and flush do not matter.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
        end else if (bus.rdy_in && bus.is_b_res) begin
            if (bus.b_res_jmp) begin
                if (bht_q[bus.b_res_pc_part] != 2'b11)
                    bht_q[bus.b_res_pc_part] <= bht_q[bus.b_res_pc_part] + 2'd1;
            end else if (bht_q[bus.b_res_pc_part] != 2'b00) begin
                bht_q[bus.b_res_pc_part] <= bht_q[bus.b_res_pc_part] - 2'd1;
            end
        end
    end

    // The request is decoded from the state register so the first pulse lands
    // in the first ready cycle after reset; gating with rdy_in keeps a held
    // REQ from looking like a second request to the cache.
    assign bus.ic_req      = rst_in & bus.rdy_in & (state_q == S_REQ);
    assign bus.ic_addr     = pc_q;
    assign bus.if_valid    = if_valid_q;
    assign bus.if_ins      = if_ins_q;
    assign bus.if_pc       = if_pc_q;
    assign bus.if_pred_jmp = if_pred_q;
endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: 2-cycle cache model, scoreboard queues for request
// addresses and consumed instructions, vector table plus corner sequences.
module tb_ifetch;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam int          LAT = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        pred;
        logic [31:0] nxt;
        logic        jalr;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        pred;
    } iss_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;

    ifetch_if #(.BHT_BITS(8)) bus ();

    ifetch #(.BHT_BITS(8)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus.master)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;
    int n_req  = 0;

    logic [31:0] imem [logic [31:0]];
    logic [31:0] q_addr [$];
    iss_t        q_iss [$];

    function automatic logic [31:0] fetch_word(input logic [31:0] a);
        return imem.exists(a) ? imem[a] : NOP;
    endfunction

    function automatic logic [31:0] enc_jal(input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_br(input logic [31:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] ins,
                                input logic pred, input logic [31:0] nxt, input logic jalr);
        vec_t v;
        v.pc = pc; v.ins = ins; v.pred = pred; v.nxt = nxt; v.jalr = jalr;
        return v;
    endfunction

    // Cache model: one response LAT cycles after each request.
    logic        c_pend;
    int          c_cnt;
    logic [31:0] c_ins;
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            c_pend <= 1'b0;
            c_cnt  <= 0;
            c_ins  <= '0;
        end else if (bus.rdy_in) begin
            if (bus.ic_req) begin
                c_pend <= 1'b1;
                c_cnt  <= LAT - 1;
                c_ins  <= fetch_word(bus.ic_addr);
            end else if (c_pend) begin
                if (c_cnt == 0) c_pend <= 1'b0;
                else            c_cnt  <= c_cnt - 1;
            end
        end
    end
    assign bus.ic_ready = c_pend && (c_cnt == 0);
    assign bus.ic_ins   = c_ins;

    // Scoreboard monitors, sampled mid-cycle.
    logic [31:0] m_addr;
    iss_t        m_iss;
    always @(negedge clk_in) begin
        if (rst_in && bus.ic_req) begin
            n_req++;
            checks++;
            if (q_addr.size() == 0) begin
                errors++;
                $display("FAIL ic_addr: unexpected request got=%h need=none", bus.ic_addr);
            end else begin
                m_addr = q_addr.pop_front();
                if (bus.ic_addr !== m_addr) begin
                    errors++;
                    $display("FAIL ic_addr: got=%h need=%h", bus.ic_addr, m_addr);
                end
            end
        end
        if (rst_in && bus.rdy_in && bus.if_valid && !bus.dec_stall && !bus.rob_clear) begin
            checks++;
            if (q_iss.size() == 0) begin
                errors++;
                $display("FAIL issue: unexpected consume pc=%h", bus.if_pc);
            end else begin
                m_iss = q_iss.pop_front();
                if (bus.if_pc !== m_iss.pc || bus.if_ins !== m_iss.ins ||
                    bus.if_pred_jmp !== m_iss.pred) begin
                    errors++;
                    $display("FAIL issue: got pc=%h ins=%h pred=%b need pc=%h ins=%h pred=%b",
                             bus.if_pc, bus.if_ins, bus.if_pred_jmp,
                             m_iss.pc, m_iss.ins, m_iss.pred);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%h need=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!bus.if_valid && n < 40);
        chk(tag, {31'd0, bus.if_valid}, 32'd1);
    endtask

    // Starting from a parked (stalled) instruction: redirect, fetch, consume once.
    task automatic run_vec(input vec_t v);
        iss_t e;
        @(posedge clk_in); #1;
        imem[v.pc] = v.ins;
        q_addr.push_back(v.pc);
        bus.rob_clear = 1'b1;
        bus.new_pc    = v.pc;
        tick();
        bus.rob_clear = 1'b0;
        wait_valid("vec_fetch");
        e.pc = v.pc; e.ins = v.ins; e.pred = v.pred;
        q_iss.push_back(e);
        if (!v.jalr) q_addr.push_back(v.nxt);
        @(posedge clk_in); #1;
        bus.dec_stall = 1'b0;
        tick();
        bus.dec_stall = 1'b1;
        if (!v.jalr) wait_valid("vec_park");
    endtask

    task automatic train(input logic taken);
        @(posedge clk_in); #1;
        bus.is_b_res      = 1'b1;
        bus.b_res_pc_part = 8'h20;
        bus.b_res_jmp     = taken;
        tick();
        bus.is_b_res = 1'b0;
    endtask

    vec_t vt [7];
    vec_t vb;
    iss_t e0;
    int   n0, bad;

    initial begin
        vt[0] = mk(32'h20, 32'h00100093, 1'b0, 32'h24, 1'b0);
        vt[1] = mk(32'h10, enc_jal(32'h20), 1'b1, 32'h30, 1'b0);
        vt[2] = mk(32'h08, enc_jal(-32'sd20), 1'b1, 32'hFFFFFFF4, 1'b0);
        vt[3] = mk(32'h40, enc_br(32'h10), 1'b0, 32'h44, 1'b0);
        vt[4] = mk(32'h60, 32'h123450B7, 1'b0, 32'h64, 1'b0);
        vt[5] = mk(32'hFFFFFFFC, 32'h00300193, 1'b0, 32'h0, 1'b0);
        vt[6] = mk(32'h70, enc_br(-32'sd32), 1'b0, 32'h74, 1'b0);

        bus.rdy_in = 1'b1;        bus.rob_clear = 1'b0;     bus.new_pc = '0;
        bus.is_b_res = 1'b0;      bus.b_res_pc_part = '0;   bus.b_res_jmp = 1'b0;
        bus.jalr_resolved = 1'b0; bus.jalr_target = '0;     bus.dec_stall = 1'b0;
        imem[32'h0] = 32'h00108093;
        imem[32'h4] = 32'h00210113;

        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_ic_req", {31'd0, bus.ic_req}, 32'd0);
        chk("rst_ic_addr", bus.ic_addr, 32'd0);
        chk("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("rst_if_ins", bus.if_ins, 32'd0);
        chk("rst_if_pc", bus.if_pc, 32'd0);
        chk("rst_if_pred", {31'd0, bus.if_pred_jmp}, 32'd0);

        // Free-running sequential fetch, parked after the third request.
        q_addr.push_back(32'h0); q_addr.push_back(32'h4); q_addr.push_back(32'h8);
        e0.pc = 32'h0; e0.ins = 32'h00108093; e0.pred = 1'b0; q_iss.push_back(e0);
        e0.pc = 32'h4; e0.ins = 32'h00210113; e0.pred = 1'b0; q_iss.push_back(e0);
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        n0 = 0;
        while (n_req < 3 && n0 < 60) begin
            @(negedge clk_in);
            n0++;
        end
        chk("seq_reqs", 32'(n_req), 32'd3);
        @(posedge clk_in); #1;
        bus.dec_stall = 1'b1;
        wait_valid("seq_park");
        chk("seq_park_pc", bus.if_pc, 32'h8);

        for (int i = 0; i < 7; i++) run_vec(vt[i]);

        // BHT entry 0x20 (pc 0x40): saturate high, step down, saturate low, step up.
        vb = mk(32'h40, enc_br(32'h10), 1'b1, 32'h50, 1'b0);
        repeat (3) train(1'b1);
        run_vec(vb);
        train(1'b0);
        run_vec(vb);
        repeat (3) train(1'b0);
        run_vec(mk(32'h40, enc_br(32'h10), 1'b0, 32'h44, 1'b0));
        repeat (2) train(1'b1);
        run_vec(vb);

        // rdy_in low freezes a ready-to-consume instruction.
        n0 = n_req;
        @(posedge clk_in); #1;
        bus.rdy_in = 1'b0; bus.dec_stall = 1'b0;
        repeat (3) @(negedge clk_in);
        @(posedge clk_in); #1;
        bus.rdy_in = 1'b1; bus.dec_stall = 1'b1;
        @(negedge clk_in);
        chk("rdy_hold_valid", {31'd0, bus.if_valid}, 32'd1);
        chk("rdy_hold_reqs", 32'(n_req - n0), 32'd0);

        // JALR waits for its target; a same-cycle flush wins.
        n0 = n_req;
        run_vec(mk(32'h80, 32'h00008067, 1'b0, 32'h0, 1'b1));
        repeat (6) @(negedge clk_in);
        chk("jalr_stuck_reqs", 32'(n_req - n0), 32'd1);
        chk("jalr_stuck_valid", {31'd0, bus.if_valid}, 32'd0);
        @(posedge clk_in); #1;
        q_addr.push_back(32'h200);
        bus.jalr_resolved = 1'b1; bus.jalr_target = 32'h200;
        tick();
        bus.jalr_resolved = 1'b0;
        wait_valid("jalr_park");
        chk("jalr_target_pc", bus.if_pc, 32'h200);
        run_vec(mk(32'h88, 32'h00008067, 1'b0, 32'h0, 1'b1));
        repeat (2) @(negedge clk_in);
        @(posedge clk_in); #1;
        q_addr.push_back(32'h300);
        bus.jalr_resolved = 1'b1; bus.jalr_target = 32'h200;
        bus.rob_clear = 1'b1;     bus.new_pc = 32'h300;
        tick();
        bus.jalr_resolved = 1'b0; bus.rob_clear = 1'b0;
        wait_valid("jalr_flush_park");
        chk("jalr_flush_pc", bus.if_pc, 32'h300);

        // Flush while waiting: the late word for 0x140 must never be issued.
        @(posedge clk_in); #1;
        imem[32'h140] = 32'hDEADC0B7;
        q_addr.push_back(32'h140);
        bus.rob_clear = 1'b1; bus.new_pc = 32'h140;
        tick();
        bus.rob_clear = 1'b0;
        @(posedge clk_in); #1;
        q_addr.push_back(32'h100);
        bus.rob_clear = 1'b1; bus.new_pc = 32'h100;
        tick();
        bus.rob_clear = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge clk_in);
            if (bus.if_valid) bad++;
        end
        chk("drop_no_valid", 32'(bad), 32'd0);
        wait_valid("drop_park");
        chk("drop_pc", bus.if_pc, 32'h100);
        chk("drop_ins", bus.if_ins, NOP);

        // Stalled outputs hold steady.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            chk("stall_valid", {31'd0, bus.if_valid}, 32'd1);
            chk("stall_pc", bus.if_pc, 32'h100);
            chk("stall_ins", bus.if_ins, NOP);
        end

        // Asynchronous reset in WAIT, off the clock edge.
        @(posedge clk_in); #1;
        q_addr.push_back(32'h180);
        bus.rob_clear = 1'b1; bus.new_pc = 32'h180;
        tick();
        bus.rob_clear = 1'b0;
        @(posedge clk_in); #3;
        rst_in = 1'b0;
        #1;
        chk("arst_ic_req", {31'd0, bus.ic_req}, 32'd0);
        chk("arst_ic_addr", bus.ic_addr, 32'd0);
        chk("arst_if_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("arst_if_ins", bus.if_ins, 32'd0);
        chk("arst_if_pc", bus.if_pc, 32'd0);
        chk("arst_if_pred", {31'd0, bus.if_pred_jmp}, 32'd0);
        chk("arst_leftover", 32'(q_addr.size() + q_iss.size()), 32'd0);
        q_addr.delete();
        q_iss.delete();
        repeat (2) @(posedge clk_in);
        #1;
        q_addr.push_back(32'h0);
        rst_in = 1'b1;
        wait_valid("arst_refetch");
        chk("arst_refetch_pc", bus.if_pc, 32'h0);
        chk("arst_refetch_ins", bus.if_ins, 32'h00108093);

        repeat (3) @(negedge clk_in);
        chk("sb_addr_empty", 32'(q_addr.size()), 32'd0);
        chk("sb_iss_empty", 32'(q_iss.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
